// File: rtl/reset_req_pkg.sv
// Shared types for the CLK_50 reset-request initiator.
//
// Contents:
//   state_e      - handshake FSM states (IDLE, ASSERT, WAIT_HI, WAIT_LO, DONE)
//   cause_e      - request source code reported on CAUSE_OUT
//   pick_cause() - fixed-priority arbitration between simultaneous triggers
package reset_req_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ASSERT  = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_SW   = 2'd1,
        CAUSE_WDT  = 2'd2,
        CAUSE_LOCK = 2'd3
    } cause_e;

    // Software beats watchdog beats lock loss. Only called when at least one
    // trigger is active, so the fall-through result is the lock-loss code.
    function automatic cause_e pick_cause(input logic sw, input logic wdt);
        if (sw) begin
            return CAUSE_SW;
        end else if (wdt) begin
            return CAUSE_WDT;
        end else begin
            return CAUSE_LOCK;
        end
    endfunction

endpackage

// File: rtl/reset_req_wdt.sv
// Watchdog down-counter for the reset-request initiator.
//
// Ports:
//   clk     - always-on CLK_50 clock
//   rst     - synchronous active-high power-on reset
//   active  - high while the initiator FSM is idle; the counter only runs then
//   enable  - watchdog enable level; low holds the counter at its reload value
//   kick    - single-cycle reload request, honoured only while active
//   reload  - unconditional reload from the FSM (exit from DONE)
//   expire  - combinational: counter at zero, enabled, active and not kicked
module reset_req_wdt #(
    parameter int unsigned WDT_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic enable,
    input  logic kick,
    input  logic reload,
    output logic expire
);

    localparam int unsigned W = $clog2(WDT_CYCLES);
    localparam logic [W-1:0] LOAD = W'(WDT_CYCLES - 1);

    logic [W-1:0] cnt;

    // A kick arriving in the same cycle the count reaches zero wins.
    assign expire = active && enable && !kick && (cnt == '0);

    // Outside IDLE the count freezes; a watchdog that expired stays at zero
    // until the FSM reloads it on its way out of DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= LOAD;
        end else if (reload || !enable || (active && kick)) begin
            cnt <= LOAD;
        end else if (active && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/reset_req_ctrl.sv
// Initiator side of the CLK_50 reset chain. Decides when the clock/reset
// generator must be re-run, drives a stretched request into its async reset
// input and follows the handshake back to completion.
//
// Handshake with the generator: RESET_REQ_OUT is held high for REQ_CYCLES
// cycles; the generator acknowledges by raising RESET_50_IN, and completion
// is RESET_50_IN low together with the synchronised PLL lock in one cycle.
// Each of the two waits is bounded by ACK_TIMEOUT cycles; expiry sets the
// sticky FAIL_OUT and abandons the request without a DONE_OUT pulse.
//
// Ports:
//   CLK_50          - 50 MHz always-on clock
//   RESET_IN        - synchronous active-high power-on reset
//   SW_REQ_IN       - single-cycle software reset request
//   WDT_EN_IN       - watchdog enable level
//   WDT_KICK_IN     - single-cycle watchdog reload
//   LOCKED_ASYNC_IN - raw PLL lock, synchronised here
//   RESET_50_IN     - generator's CLK_50-domain reset output
//   RESET_REQ_OUT   - request into the generator's async reset input
//   BUSY_OUT        - high whenever the FSM is not IDLE
//   CAUSE_OUT       - source of the most recent request (cause_e encoding)
//   DONE_OUT        - one-cycle pulse on successful completion
//   FAIL_OUT        - sticky handshake-timeout flag
//   fsm_state       - current FSM state, for observation
module reset_req_ctrl
    import reset_req_pkg::*;
#(
    parameter int unsigned REQ_CYCLES       = 8,
    parameter int unsigned WDT_CYCLES       = 50000000,
    parameter int unsigned LOCK_LOSS_CYCLES = 64,
    parameter int unsigned ACK_TIMEOUT      = 4096
) (
    input  logic       CLK_50,
    input  logic       RESET_IN,
    input  logic       SW_REQ_IN,
    input  logic       WDT_EN_IN,
    input  logic       WDT_KICK_IN,
    input  logic       LOCKED_ASYNC_IN,
    input  logic       RESET_50_IN,
    output logic       RESET_REQ_OUT,
    output logic       BUSY_OUT,
    output logic [1:0] CAUSE_OUT,
    output logic       DONE_OUT,
    output logic       FAIL_OUT,
    output state_e     fsm_state
);

    localparam int unsigned RW = $clog2(REQ_CYCLES);
    localparam int unsigned LW = $clog2(LOCK_LOSS_CYCLES);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT);

    localparam logic [RW-1:0] REQ_LAST  = RW'(REQ_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_LOSS_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

    state_e        state_q;
    state_e        state_d;
    cause_e        cause_q;
    logic          fail_q;
    logic [RW-1:0] req_cnt;
    logic [LW-1:0] lock_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          locked_m;
    logic          locked_s;

    logic idle;
    logic sw_trip;
    logic wdt_trip;
    logic lock_trip;
    logic any_trip;
    logic load_tmo;
    logic fail_set;
    logic wdt_reload;

    // Two-flop synchroniser for the raw PLL lock (2-cycle latency).
    always_ff @(posedge CLK_50) begin
        if (RESET_IN) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= LOCKED_ASYNC_IN;
            locked_s <= locked_m;
        end
    end

    reset_req_wdt #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .clk   (CLK_50),
        .rst   (RESET_IN),
        .active(idle),
        .enable(WDT_EN_IN),
        .kick  (WDT_KICK_IN),
        .reload(wdt_reload),
        .expire(wdt_trip)
    );

    assign idle      = (state_q == IDLE);
    assign sw_trip   = idle && SW_REQ_IN;
    assign lock_trip = idle && !locked_s && (lock_cnt == LOCK_LAST);
    assign any_trip  = sw_trip || wdt_trip || lock_trip;

    always_ff @(posedge CLK_50) begin
        if (RESET_IN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_tmo   = 1'b0;
        fail_set   = 1'b0;
        wdt_reload = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_trip) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (req_cnt == '0) begin
                    state_d  = WAIT_HI;
                    load_tmo = 1'b1;
                end
            end
            WAIT_HI: begin
                // An acknowledge in the final timeout cycle still counts.
                if (RESET_50_IN) begin
                    state_d  = WAIT_LO;
                    load_tmo = 1'b1;
                end else if (tmo_cnt == '0) begin
                    state_d  = IDLE;
                    fail_set = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!RESET_50_IN && locked_s) begin
                    state_d = DONE;
                end else if (tmo_cnt == '0) begin
                    state_d  = IDLE;
                    fail_set = 1'b1;
                end
            end
            DONE: begin
                state_d    = IDLE;
                wdt_reload = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request stretch counter: loaded on the trigger, counts down in ASSERT.
    always_ff @(posedge CLK_50) begin
        if (RESET_IN) begin
            req_cnt <= '0;
        end else if (any_trip) begin
            req_cnt <= REQ_LAST;
        end else if ((state_q == ASSERT) && (req_cnt != '0)) begin
            req_cnt <= req_cnt - 1'b1;
        end
    end

    // Handshake timeout: reloaded on entry to each wait state.
    always_ff @(posedge CLK_50) begin
        if (RESET_IN) begin
            tmo_cnt <= '0;
        end else if (load_tmo) begin
            tmo_cnt <= TMO_LAST;
        end else if (((state_q == WAIT_HI) || (state_q == WAIT_LO)) && (tmo_cnt != '0)) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    // Lock-loss up-counter: only meaningful in IDLE, saturates at the trip value.
    always_ff @(posedge CLK_50) begin
        if (RESET_IN || !idle || locked_s) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LOCK_LAST) begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (RESET_IN) begin
            cause_q <= CAUSE_NONE;
        end else if (any_trip) begin
            cause_q <= pick_cause(sw_trip, wdt_trip);
        end
    end

    always_ff @(posedge CLK_50) begin
        if (RESET_IN) begin
            fail_q <= 1'b0;
        end else if (fail_set) begin
            fail_q <= 1'b1;
        end
    end

    // The request is gated by RESET_IN so it drops in the same cycle a
    // power-on reset arrives rather than one cycle later.
    assign RESET_REQ_OUT = (state_q == ASSERT) && !RESET_IN;
    assign BUSY_OUT      = !idle;
    assign CAUSE_OUT     = cause_q;
    assign DONE_OUT      = (state_q == DONE);
    assign FAIL_OUT      = fail_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_reset_req_ctrl.sv
// Directed testbench for reset_req_ctrl (watchdog period shortened to 100).
module tb_reset_req_ctrl;
    import reset_req_pkg::*;

    logic       CLK_50          = 1'b0;
    logic       RESET_IN        = 1'b1;
    logic       SW_REQ_IN       = 1'b0;
    logic       WDT_EN_IN       = 1'b0;
    logic       WDT_KICK_IN     = 1'b0;
    logic       LOCKED_ASYNC_IN = 1'b1;
    logic       RESET_50_IN     = 1'b0;
    logic       RESET_REQ_OUT;
    logic       BUSY_OUT;
    logic [1:0] CAUSE_OUT;
    logic       DONE_OUT;
    logic       FAIL_OUT;
    state_e     fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Generator model: reset output follows the request and lingers for
    // 20 cycles after it drops.
    logic model_en   = 1'b0;
    int   model_hold = 0;

    reset_req_ctrl #(
        .REQ_CYCLES      (8),
        .WDT_CYCLES      (100),
        .LOCK_LOSS_CYCLES(64),
        .ACK_TIMEOUT     (4096)
    ) dut (
        .CLK_50         (CLK_50),
        .RESET_IN       (RESET_IN),
        .SW_REQ_IN      (SW_REQ_IN),
        .WDT_EN_IN      (WDT_EN_IN),
        .WDT_KICK_IN    (WDT_KICK_IN),
        .LOCKED_ASYNC_IN(LOCKED_ASYNC_IN),
        .RESET_50_IN    (RESET_50_IN),
        .RESET_REQ_OUT  (RESET_REQ_OUT),
        .BUSY_OUT       (BUSY_OUT),
        .CAUSE_OUT      (CAUSE_OUT),
        .DONE_OUT       (DONE_OUT),
        .FAIL_OUT       (FAIL_OUT),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / time limit ----------------
    always #10 CLK_50 = ~CLK_50;

    initial begin
        #(10_000_000);
        $display("FAIL global_timeout: got no finish expected finish within time limit");
        $fatal(1, "time limit");
    end

    always @(negedge CLK_50) begin
        if (!model_en) begin
            model_hold  = 0;
            RESET_50_IN = 1'b0;
        end else if (RESET_REQ_OUT) begin
            model_hold  = 20;
            RESET_50_IN = 1'b1;
        end else if (model_hold != 0) begin
            model_hold  = model_hold - 1;
            RESET_50_IN = (model_hold != 0);
        end
    end

    // Observation window: k=1 is the first falling edge after the caller's
    // stimulus. Clears SW_REQ_IN, drops WDT_EN_IN once a request is seen, and
    // releases the PLL lock at k == lock_release (0 = never).
    task automatic observe(input int n, input int lock_release,
                           output int first_hi, output int last_hi, output int hi_cnt,
                           output int done_cnt, output int done_k);
        first_hi = -1; last_hi = -1; hi_cnt = 0; done_cnt = 0; done_k = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK_50);
            SW_REQ_IN = 1'b0;
            if (RESET_REQ_OUT) begin
                if (first_hi < 0) first_hi = k;
                last_hi = k;
                hi_cnt++;
                WDT_EN_IN = 1'b0;
            end
            if (DONE_OUT) begin
                done_cnt++;
                done_k = k;
            end
            if (k == lock_release) LOCKED_ASYNC_IN = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET_IN = 1'b1;
        repeat (2) @(negedge CLK_50);
        n_cmp++; if (RESET_REQ_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b expected 0", RESET_REQ_OUT); end
        n_cmp++; if (BUSY_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", BUSY_OUT); end
        n_cmp++; if (CAUSE_OUT !== 2'd0) begin n_bad++; $display("FAIL rst_cause: got %0d expected 0", CAUSE_OUT); end
        n_cmp++; if (DONE_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", DONE_OUT); end
        n_cmp++; if (FAIL_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_fail: got %b expected 0", FAIL_OUT); end
        n_cmp++; if (fsm_state !== IDLE) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", fsm_state); end
        RESET_IN = 1'b0;
        repeat (4) @(negedge CLK_50);
    endtask

    task automatic test_sw_request();
        int f, l, h, d, dk;
        int busy_after;
        model_en  = 1'b1;
        SW_REQ_IN = 1'b1;
        observe(40, 0, f, l, h, d, dk);
        // Request at 0 -> high 1..8; generator low sampled at 29 -> DONE at 29.
        n_cmp++; if (f !== 1) begin n_bad++; $display("FAIL sw_first_hi: got %0d expected 1", f); end
        n_cmp++; if (l !== 8) begin n_bad++; $display("FAIL sw_last_hi: got %0d expected 8", l); end
        n_cmp++; if (h !== 8) begin n_bad++; $display("FAIL sw_hi_cnt: got %0d expected 8", h); end
        n_cmp++; if (CAUSE_OUT !== 2'd1) begin n_bad++; $display("FAIL sw_cause: got %0d expected 1", CAUSE_OUT); end
        n_cmp++; if (d !== 1) begin n_bad++; $display("FAIL sw_done_cnt: got %0d expected 1", d); end
        n_cmp++; if (dk !== 29) begin n_bad++; $display("FAIL sw_done_k: got %0d expected 29", dk); end
        // Re-run a short request to look at BUSY on the cycle after DONE.
        SW_REQ_IN  = 1'b1;
        busy_after = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK_50);
            SW_REQ_IN = 1'b0;
            if (k == 30) busy_after = int'(BUSY_OUT);
        end
        n_cmp++; if (busy_after !== 0) begin n_bad++; $display("FAIL sw_busy_after_done: got %0d expected 0", busy_after); end
    endtask

    task automatic test_watchdog_expiry();
        int f, l, h, d, dk;
        WDT_EN_IN = 1'b1;
        observe(140, 0, f, l, h, d, dk);
        // 100-cycle period: zero sampled on edge 100 -> request visible at 100.
        n_cmp++; if (f !== 100) begin n_bad++; $display("FAIL wdt_first_hi: got %0d expected 100", f); end
        n_cmp++; if (h !== 8) begin n_bad++; $display("FAIL wdt_hi_cnt: got %0d expected 8", h); end
        n_cmp++; if (CAUSE_OUT !== 2'd2) begin n_bad++; $display("FAIL wdt_cause: got %0d expected 2", CAUSE_OUT); end
        n_cmp++; if (dk !== 128) begin n_bad++; $display("FAIL wdt_done_k: got %0d expected 128", dk); end
        n_cmp++; if (BUSY_OUT !== 1'b0) begin n_bad++; $display("FAIL wdt_idle_end: got %b expected 0", BUSY_OUT); end
    endtask

    task automatic test_watchdog_kick();
        int busy_cnt = 0;
        int f = -1;
        WDT_EN_IN = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            WDT_KICK_IN = ((i % 50) == 49);
            @(negedge CLK_50);
            if (BUSY_OUT) busy_cnt++;
        end
        WDT_KICK_IN = 1'b0;
        WDT_EN_IN   = 1'b0;
        n_cmp++; if (busy_cnt !== 0) begin n_bad++; $display("FAIL kick_no_request: got %0d busy cycles expected 0", busy_cnt); end
        // Kick exactly on the zero cycle: no trigger, next expiry 100 later.
        @(negedge CLK_50);
        WDT_EN_IN = 1'b1;
        for (int k = 1; k <= 240; k++) begin
            WDT_KICK_IN = (k == 100);
            @(negedge CLK_50);
            WDT_KICK_IN = 1'b0;
            if (RESET_REQ_OUT && f < 0) begin
                f = k;
                WDT_EN_IN = 1'b0;
            end
        end
        n_cmp++; if (f !== 200) begin n_bad++; $display("FAIL kick_at_zero_first_hi: got %0d expected 200", f); end
        n_cmp++; if (BUSY_OUT !== 1'b0) begin n_bad++; $display("FAIL kick_idle_end: got %b expected 0", BUSY_OUT); end
    endtask

    task automatic test_lock_loss();
        int f, l, h, d, dk;
        LOCKED_ASYNC_IN = 1'b0;
        observe(80, 60, f, l, h, d, dk);
        n_cmp++; if (h !== 0) begin n_bad++; $display("FAIL lock60_hi_cnt: got %0d expected 0", h); end
        n_cmp++; if (CAUSE_OUT !== 2'd2) begin n_bad++; $display("FAIL lock60_cause_held: got %0d expected 2", CAUSE_OUT); end
        LOCKED_ASYNC_IN = 1'b0;
        observe(130, 70, f, l, h, d, dk);
        // Sync delay 2, then 64 unlocked cycles counted 0..63 -> trip at 66.
        n_cmp++; if (f !== 66) begin n_bad++; $display("FAIL lock70_first_hi: got %0d expected 66", f); end
        n_cmp++; if (CAUSE_OUT !== 2'd3) begin n_bad++; $display("FAIL lock70_cause: got %0d expected 3", CAUSE_OUT); end
        n_cmp++; if (dk !== 94) begin n_bad++; $display("FAIL lock70_done_k: got %0d expected 94", dk); end
        n_cmp++; if (BUSY_OUT !== 1'b0) begin n_bad++; $display("FAIL lock70_idle_end: got %b expected 0", BUSY_OUT); end
    endtask

    task automatic test_simultaneous();
        int f, l, h, d, dk;
        WDT_EN_IN = 1'b1;
        repeat (99) @(negedge CLK_50);
        n_cmp++; if (BUSY_OUT !== 1'b0) begin n_bad++; $display("FAIL simul_pre_idle: got %b expected 0", BUSY_OUT); end
        SW_REQ_IN = 1'b1;
        observe(60, 0, f, l, h, d, dk);
        n_cmp++; if (CAUSE_OUT !== 2'd1) begin n_bad++; $display("FAIL simul_cause: got %0d expected 1", CAUSE_OUT); end
        n_cmp++; if (f !== 1) begin n_bad++; $display("FAIL simul_first_hi: got %0d expected 1", f); end
        n_cmp++; if (h !== 8) begin n_bad++; $display("FAIL simul_hi_cnt: got %0d expected 8", h); end
        n_cmp++; if (l !== 8) begin n_bad++; $display("FAIL simul_last_hi: got %0d expected 8", l); end
        n_cmp++; if (d !== 1) begin n_bad++; $display("FAIL simul_done_cnt: got %0d expected 1", d); end
    endtask

    task automatic test_timeout();
        int f, l, h, d, dk;
        int fail_k     = -1;
        int busy_fail  = -1;
        int done_cnt   = 0;
        model_en  = 1'b0;
        SW_REQ_IN = 1'b1;
        for (int k = 1; k <= 4110; k++) begin
            @(negedge CLK_50);
            SW_REQ_IN = 1'b0;
            if (FAIL_OUT && fail_k < 0) begin
                fail_k    = k;
                busy_fail = int'(BUSY_OUT);
            end
            if (DONE_OUT) done_cnt++;
        end
        // WAIT_HI entered at 9; 4096 cycles later the flag is visible.
        n_cmp++; if (fail_k !== 4105) begin n_bad++; $display("FAIL tmo_fail_k: got %0d expected 4105", fail_k); end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL tmo_done_cnt: got %0d expected 0", done_cnt); end
        n_cmp++; if (busy_fail !== 0) begin n_bad++; $display("FAIL tmo_busy_at_fail: got %0d expected 0", busy_fail); end
        model_en  = 1'b1;
        SW_REQ_IN = 1'b1;
        observe(40, 0, f, l, h, d, dk);
        n_cmp++; if (d !== 1) begin n_bad++; $display("FAIL tmo_retry_done: got %0d expected 1", d); end
        n_cmp++; if (FAIL_OUT !== 1'b1) begin n_bad++; $display("FAIL tmo_fail_sticky: got %b expected 1", FAIL_OUT); end
    endtask

    task automatic test_mid_reset();
        int f, l, h, d, dk;
        model_en  = 1'b0;
        SW_REQ_IN = 1'b1;
        @(negedge CLK_50);
        SW_REQ_IN = 1'b0;
        repeat (2) @(negedge CLK_50);
        n_cmp++; if (RESET_REQ_OUT !== 1'b1) begin n_bad++; $display("FAIL mid_req_before: got %b expected 1", RESET_REQ_OUT); end
        RESET_IN = 1'b1;
        #1;
        n_cmp++; if (RESET_REQ_OUT !== 1'b0) begin n_bad++; $display("FAIL mid_req_immediate: got %b expected 0", RESET_REQ_OUT); end
        @(negedge CLK_50);
        n_cmp++; if (RESET_REQ_OUT !== 1'b0) begin n_bad++; $display("FAIL mid_req_next: got %b expected 0", RESET_REQ_OUT); end
        n_cmp++; if (BUSY_OUT !== 1'b0) begin n_bad++; $display("FAIL mid_busy_next: got %b expected 0", BUSY_OUT); end
        n_cmp++; if (FAIL_OUT !== 1'b0) begin n_bad++; $display("FAIL mid_fail_cleared: got %b expected 0", FAIL_OUT); end
        n_cmp++; if (CAUSE_OUT !== 2'd0) begin n_bad++; $display("FAIL mid_cause_cleared: got %0d expected 0", CAUSE_OUT); end
        RESET_IN = 1'b0;
        repeat (4) @(negedge CLK_50);
        model_en  = 1'b1;
        SW_REQ_IN = 1'b1;
        observe(40, 0, f, l, h, d, dk);
        n_cmp++; if (f !== 1) begin n_bad++; $display("FAIL mid_after_first_hi: got %0d expected 1", f); end
        n_cmp++; if (h !== 8) begin n_bad++; $display("FAIL mid_after_hi_cnt: got %0d expected 8", h); end
        n_cmp++; if (dk !== 29) begin n_bad++; $display("FAIL mid_after_done_k: got %0d expected 29", dk); end
        n_cmp++; if (CAUSE_OUT !== 2'd1) begin n_bad++; $display("FAIL mid_after_cause: got %0d expected 1", CAUSE_OUT); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sw_request();
        test_watchdog_expiry();
        test_watchdog_kick();
        test_lock_loss();
        test_simultaneous();
        test_timeout();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
